serial_core_scheduler: RTL and testbench

Shares one serial-input Moore detector core (ports x/out, 4-state) among N requesters. Each requester submits a W-bit pattern. The scheduler arbitrates round-robin, clears the core, and shifts the pattern into the core's x input LSB-first, one bit per clock. It counts the clock cycles in which the core's out is high and returns that count to the winning requester. It sits between the requester logic and a single detector core instance.

---
 rtl/serial_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/serial_core_scheduler.sv | 125 ++++++++++++
 tb/tb_serial_core_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sched_pkg.sv
// Shared types and default sizing for the serial core scheduler.
// Requesters submit patterns that are streamed into one detector core.
package serial_sched_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request after 'last', with wrap.
// The pointer register lives in the parent.
module rr_arbiter
    import serial_sched_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // Walk the requesters starting one past the last winner; the first hit wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s        = IW'((int'(last) + k) % N);
            hit_s        = ~found_s & req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/serial_core_scheduler.sv
// Shares one serial Moore detector core among N requesters: grants round-robin,
// clears the core, shifts the pattern LSB-first and reports the out-high count.
module serial_core_scheduler
    import serial_sched_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             req,
    input  logic [N-1:0][W-1:0]      pattern,
    output logic [N-1:0]             gnt,
    output logic                     done,
    output logic [$clog2(N)-1:0]     result_id,
    output logic [$clog2(W+1)-1:0]   result,
    output logic                     core_rst,
    output logic                     core_x,
    input  logic                     core_out
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(W+1);
    localparam int BW = $clog2(W);

    sched_state_t  state_r;
    sched_state_t  state_nx_s;
    logic [IW-1:0] last_r;
    logic [IW-1:0] id_r;
    logic [W-1:0]  pat_r;
    logic [CW-1:0] cnt_r;
    logic [BW-1:0] bit_idx_r;
    logic [CW-1:0] result_r;
    logic [IW-1:0] result_id_r;
    logic          done_r;
    logic [N-1:0]  grant_s;
    logic [IW-1:0] win_id_s;

    rr_arbiter #(.N(N)) u_arb (
        .req   (req),
        .last  (last_r),
        .grant (grant_s)
    );

    // One-hot grant to index.
    always_comb begin
        win_id_s = '0;
        for (int i = 0; i < N; i++) begin
            win_id_s = win_id_s | (grant_s[i] ? IW'(i) : '0);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) state_nx_s = CLEAR;
                else      state_nx_s = IDLE;
            end
            CLEAR:  state_nx_s = SHIFT;
            SHIFT: begin
                if (bit_idx_r == BW'(W-1)) state_nx_s = DRAIN;
                else                       state_nx_s = SHIFT;
            end
            DRAIN:  state_nx_s = REPORT;
            REPORT: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and datapath; a reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            last_r      <= IW'(N-1);
            id_r        <= '0;
            pat_r       <= '0;
            cnt_r       <= '0;
            bit_idx_r   <= '0;
            result_r    <= '0;
            result_id_r <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            // done is registered so it lines up with the freshly loaded result
            done_r  <= (state_r == DRAIN);
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        id_r   <= win_id_s;
                        pat_r  <= pattern[win_id_s];
                        last_r <= win_id_s;
                    end else begin
                        id_r <= id_r;
                    end
                end
                CLEAR: begin
                    cnt_r     <= '0;
                    bit_idx_r <= '0;
                end
                SHIFT: begin
                    bit_idx_r <= bit_idx_r + BW'(1);
                    // the first SHIFT cycle still sees the cleared core, not a bit's effect
                    if (bit_idx_r != '0) cnt_r <= cnt_r + CW'(core_out);
                    else                 cnt_r <= cnt_r;
                end
                DRAIN: begin
                    result_r    <= cnt_r + CW'(core_out);
                    result_id_r <= id_r;
                end
                REPORT: cnt_r <= cnt_r;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign gnt       = (!reset && state_r == IDLE) ? grant_s : '0;
    assign core_rst  = reset | (state_r == CLEAR);
    assign core_x    = (!reset && state_r == SHIFT) ? pat_r[bit_idx_r] : 1'b0;
    assign done      = done_r & ~reset;
    assign result    = reset ? '0 : result_r;
    assign result_id = reset ? '0 : result_id_r;

endmodule

// File: tb/tb_serial_core_scheduler.sv
// Directed bench for serial_core_scheduler with a 4-state Moore reference core.
// s0:x?s3:s1, s1:x?s2:s0, s2->s1, s3->s1; out=0 only in s0.
module tb_serial_core_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int CW = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req = '0;
    logic [N-1:0][W-1:0]  pattern = '0;
    logic [N-1:0]         gnt;
    logic                 done;
    logic [IW-1:0]        result_id;
    logic [CW-1:0]        result;
    logic                 core_rst;
    logic                 core_x;
    logic                 core_out;
    logic [1:0]           core_s;

    int total = 0;
    int bad   = 0;

    serial_core_scheduler #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .pattern   (pattern),
        .gnt       (gnt),
        .done      (done),
        .result_id (result_id),
        .result    (result),
        .core_rst  (core_rst),
        .core_x    (core_x),
        .core_out  (core_out)
    );

    always #5 clk = ~clk;

    // Reference detector core.
    always @(posedge clk) begin
        if (core_rst) core_s <= 2'd0;
        else begin
            case (core_s)
                2'd0: core_s <= core_x ? 2'd3 : 2'd1;
                2'd1: core_s <= core_x ? 2'd2 : 2'd0;
                default: core_s <= 2'd1;
            endcase
        end
    end
    assign core_out = (core_s != 2'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a job from IDLE and observes it through done; returns at the following IDLE cycle.
    task automatic run_job(input logic [N-1:0] r, input logic [N-1:0][W-1:0] pat_late,
                           output logic [N-1:0] g0, output int done_cyc,
                           output logic [CW-1:0] res, output logic [IW-1:0] rid,
                           output int rst_cnt, output int rst_first, output int x_ones);
        req = r;
        #1;
        g0 = gnt;
        done_cyc = -1; rst_cnt = 0; rst_first = -1; x_ones = 0; res = '0; rid = '0;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            step();
            if (c == 1) begin
                req = '0;
                pattern = pat_late;
            end
            if (core_rst) begin
                rst_cnt++;
                if (rst_first < 0) rst_first = c;
            end
            if (core_x) x_ones++;
            if (done) begin
                done_cyc = c;
                res = result;
                rid = result_id;
            end
        end
        step();
    endtask

    task automatic test_reset();
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (gnt !== 4'b0000 || done !== 1'b0 || core_rst !== 1'b1 || core_x !== 1'b0 ||
                result !== 4'd0 || result_id !== 2'd0) begin
                bad++;
                $display("FAIL reset_outputs: got gnt=%b done=%b core_rst=%b core_x=%b result=%0d id=%0d, expected 0000 0 1 0 0 0",
                         gnt, done, core_rst, core_x, result, result_id);
            end
        end
        req = '0;
        reset = 1'b0;
        step();
        total++;
        if (core_rst !== 1'b0 || done !== 1'b0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_reset: got core_rst=%b done=%b gnt=%b, expected 0 0 0000", core_rst, done, gnt);
        end
    endtask

    task automatic test_round_robin();
        int gcyc[5];
        int gid[5];
        int ng;
        int multi;
        ng = 0; multi = 0;
        pattern = '0;
        req = 4'b1111;
        #1;
        for (int c = 0; c < 50; c++) begin
            if (c > 0) step();
            if ($countones(gnt) > 1) multi++;
            if (gnt != '0 && ng < 5) begin
                gcyc[ng] = c;
                gid[ng] = 0;
                for (int i = 0; i < N; i++) if (gnt[i]) gid[ng] = i;
                ng++;
            end
        end
        req = '0;
        for (int i = 0; i < 12; i++) step();
        total++;
        if (multi !== 0) begin
            bad++;
            $display("FAIL rr_onehot: got %0d multi-bit gnt cycles, expected 0", multi);
        end
        total++;
        if (ng !== 5) begin
            bad++;
            $display("FAIL rr_count: got %0d grants, expected 5", ng);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (gid[k] !== (k % 4) || gcyc[k] !== k * 12) begin
                    bad++;
                    $display("FAIL rr_grant%0d: got id=%0d cycle=%0d, expected id=%0d cycle=%0d",
                             k, gid[k], gcyc[k], k % 4, k * 12);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [N-1:0] g0; int dc, rc, rf, xo; logic [CW-1:0] res; logic [IW-1:0] rid;
        pattern = '0;
        run_job(4'b0001, pattern, g0, dc, res, rid, rc, rf, xo);
        total++;
        if (g0 !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b expected 0001", g0); end
        total++;
        if (dc !== 11) begin bad++; $display("FAIL single_latency: got %0d expected 11", dc); end
        total++;
        if (res !== 4'd4 || rid !== 2'd0) begin
            bad++; $display("FAIL single_result: got result=%0d id=%0d expected 4 0", res, rid);
        end
        total++;
        if (xo !== 0) begin bad++; $display("FAIL single_core_x: got %0d high cycles expected 0", xo); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_all_ones();
        logic [N-1:0] g0; int dc, rc, rf, xo; logic [CW-1:0] res; logic [IW-1:0] rid;
        pattern = '0;
        pattern[1] = 8'hFF;
        run_job(4'b0010, pattern, g0, dc, res, rid, rc, rf, xo);
        total++;
        if (g0 !== 4'b0010 || dc !== 11) begin
            bad++; $display("FAIL ones_gnt_latency: got gnt=%b done_cycle=%0d expected 0010 11", g0, dc);
        end
        total++;
        if (res !== 4'd8 || rid !== 2'd1) begin
            bad++; $display("FAIL ones_result: got result=%0d id=%0d expected 8 1", res, rid);
        end
        total++;
        if (rc !== 1 || rf !== 1) begin
            bad++; $display("FAIL ones_core_rst: got count=%0d first=%0d expected 1 1", rc, rf);
        end
        total++;
        if (xo !== 8) begin bad++; $display("FAIL ones_core_x: got %0d high cycles expected 8", xo); end
    endtask

    task automatic test_mixed();
        logic [N-1:0] g0; int dc, rc, rf, xo; logic [CW-1:0] res; logic [IW-1:0] rid;
        pattern = '0;
        pattern[2] = 8'h02;
        run_job(4'b0100, pattern, g0, dc, res, rid, rc, rf, xo);
        total++;
        if (res !== 4'd5 || rid !== 2'd2 || dc !== 11) begin
            bad++; $display("FAIL mixed_result: got result=%0d id=%0d done_cycle=%0d expected 5 2 11", res, rid, dc);
        end
        step();
        step();
        total++;
        if (result !== 4'd5 || result_id !== 2'd2) begin
            bad++; $display("FAIL mixed_hold: got result=%0d id=%0d expected 5 2", result, result_id);
        end
    endtask

    task automatic test_pattern_stability();
        logic [N-1:0] g0; int dc, rc, rf, xo; logic [CW-1:0] res; logic [IW-1:0] rid;
        logic [N-1:0][W-1:0] late;
        pattern = '0;
        late = '0;
        late[0] = 8'hFF;
        run_job(4'b0001, late, g0, dc, res, rid, rc, rf, xo);
        total++;
        if (res !== 4'd4 || rid !== 2'd0) begin
            bad++; $display("FAIL stable_result: got result=%0d id=%0d expected 4 0", res, rid);
        end
        pattern = '0;
    endtask

    task automatic test_reset_mid_job();
        logic [N-1:0] g0; int dc, rc, rf, xo; logic [CW-1:0] res; logic [IW-1:0] rid;
        int ndone;
        pattern = '0;
        pattern[2] = 8'hFF;
        req = 4'b0100;
        #1;
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL midrst_gnt: got %b expected 0100", gnt); end
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) req = '0;
        end
        step();
        reset = 1'b1;
        #1;
        total++;
        if (core_rst !== 1'b1 || core_x !== 1'b0 || done !== 1'b0 || gnt !== 4'b0000) begin
            bad++; $display("FAIL midrst_outputs: got core_rst=%b core_x=%b done=%b gnt=%b expected 1 0 0 0000",
                            core_rst, core_x, done, gnt);
        end
        step();
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            if (done) ndone++;
            step();
        end
        total++;
        if (ndone !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", ndone); end
        pattern[1] = 8'hFF;
        run_job(4'b1010, pattern, g0, dc, res, rid, rc, rf, xo);
        total++;
        if (g0 !== 4'b0010) begin bad++; $display("FAIL midrst_next_gnt: got %b expected 0010", g0); end
        total++;
        if (res !== 4'd8 || rid !== 2'd1 || dc !== 11) begin
            bad++; $display("FAIL midrst_next_result: got result=%0d id=%0d done_cycle=%0d expected 8 1 11", res, rid, dc);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_all_ones();
        test_mixed();
        test_pattern_stability();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
